// File: rtl/uart_tx_line_arbiter_pkg.sv
// Shared types and helpers for the line-granular UART TX arbiter.
// States, the newline byte and the packed-byte slicing helper.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        ISSUE,
        DRAIN
    } state_t;

    localparam int          BYTE_W  = 8;
    localparam int          MAX_REQ = 8;
    localparam logic [7:0]  NEWLINE = 8'h0a;

    function automatic logic [7:0] req_byte(
        input logic [MAX_REQ*BYTE_W-1:0] vec,
        input int unsigned               idx
    );
        return vec[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/uart_tx_line_arbiter_if.sv
// Requester and serializer signal bundle of the UART TX line arbiter.
// slave = arbiter side, master = requesters plus serializer side.
interface uart_tx_line_arbiter_if
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int PAYLOAD_BITS = BYTE_W
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [N_REQ-1:0]              req_ready;
    logic [PAYLOAD_BITS-1:0]       uart_tx_data;
    logic                          uart_tx_en;
    logic                          uart_tx_busy;
    logic [$clog2(N_REQ)-1:0]      grant_id;
    logic                          grant_active;
    logic                          line_done;

    modport slave (
        input  req_valid,
        input  req_data,
        input  uart_tx_busy,
        output req_ready,
        output uart_tx_data,
        output uart_tx_en,
        output grant_id,
        output grant_active,
        output line_done
    );

    modport master (
        output req_valid,
        output req_data,
        output uart_tx_busy,
        input  req_ready,
        input  uart_tx_data,
        input  uart_tx_en,
        input  grant_id,
        input  grant_active,
        input  line_done
    );

endinterface

// File: rtl/uart_tx_line_arbiter_rr_picker.sv
// Rotating-priority picker: first valid index at or after the pointer,
// wrapping modulo N_REQ. Purely combinational.
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] pick_idx,
    output logic                     pick_any
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest valid index wins.
    always_comb begin
        pick_idx = '0;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[w_idx]) begin
                pick_idx = w_idx;
            end
        end
        pick_any = |req_valid;
    end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Line-granular arbiter sharing one UART serializer between N requesters.
// Optional owner-idle release is built with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_line_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_line_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N_REQ);

    // Newline detection is a fixed 8-bit compare.
    if (PAYLOAD_BITS != 8) begin : g_bad_width
        $error("uart_tx_line_arbiter: PAYLOAD_BITS must be 8");
    end

    state_t                  r_state;
    state_t                  w_next;
    logic [IW-1:0]           r_rr_ptr;
    logic [IW-1:0]           r_grant_id;
    logic [IW-1:0]           w_rr_next;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_pick_any;
    logic [7:0]              r_last_byte;
    logic [7:0]              w_own_byte;
    logic [MAX_REQ*8-1:0]    w_data_ext;
    logic                    w_own_valid;
    logic                    w_xmit;
    logic                    w_line_end;
    logic                    w_timeout;
    logic                    w_release;

    rr_picker #(
        .N_REQ     (N_REQ)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .pick_idx  (w_pick_idx),
        .pick_any  (w_pick_any)
    );

    assign w_data_ext  = (MAX_REQ*8)'(bus.req_data);
    assign w_own_byte  = req_byte(w_data_ext, int'(r_grant_id));
    assign w_own_valid = bus.req_valid[r_grant_id];
    assign w_xmit      = (r_state == OWN) && w_own_valid
                         && !bus.uart_tx_busy;
    assign w_line_end  = (r_state == DRAIN) && !bus.uart_tx_busy
                         && (r_last_byte == NEWLINE);
    assign w_rr_next   = (r_grant_id == IW'(N_REQ - 1))
                         ? '0 : r_grant_id + 1'b1;
    assign w_release   = w_line_end || w_timeout;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    logic [TW-1:0] r_idle_cnt;

    assign w_timeout = (r_state == OWN) && !w_own_valid
                       && (r_idle_cnt == TW'(IDLE_TIMEOUT - 1));

    // Count owner-idle OWN cycles; any accept or release restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_xmit || w_timeout) begin
            r_idle_cnt <= '0;
        end else if ((r_state == OWN) && !w_own_valid) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    if (IDLE_TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_line_arbiter: IDLE_TIMEOUT must be positive");
    end

    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ISSUE skips busy to cover its rise latency.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_next = OWN;
                end
            end
            OWN: begin
                if (w_xmit) begin
                    w_next = ISSUE;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            ISSUE: begin
                w_next = DRAIN;
            end
            DRAIN: begin
                if (!bus.uart_tx_busy) begin
                    w_next = w_line_end ? IDLE : OWN;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Owner, fairness pointer and last-sent byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_last_byte <= '0;
        end else begin
            if ((r_state == IDLE) && w_pick_any) begin
                r_grant_id <= w_pick_idx;
            end
            if (w_release) begin
                r_rr_ptr <= w_rr_next;
            end
            if (w_xmit) begin
                r_last_byte <= w_own_byte;
            end
        end
    end

    // Outputs: strobes only on the accept cycle, grant from state.
    always_comb begin
        bus.req_ready    = '0;
        bus.uart_tx_en   = w_xmit;
        bus.uart_tx_data = '0;
        bus.grant_id     = r_grant_id;
        bus.grant_active = (r_state != IDLE);
        bus.line_done    = w_line_end;
        if (w_xmit) begin
            bus.req_ready[r_grant_id] = 1'b1;
            bus.uart_tx_data          = w_own_byte;
        end
    end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Self-checking bench for uart_tx_line_arbiter with a busy-model serializer.
// Expected bytes go to a scoreboard queue and are checked on each en strobe.
module tb_uart_tx_line_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_line_arbiter_if #(.N_REQ(N), .PAYLOAD_BITS(8)) bus ();

    uart_tx_line_arbiter #(
        .N_REQ        (N),
        .PAYLOAD_BITS (8),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] src_q [N][$];
    logic [7:0] exp_q [$];
    int         grant_log [$];
    int         ser_cnt = 0;
    bit         stall = 1'b0;
    bit         s_en, s_ld, s_ga, prev_ga, prev_en;
    logic [N-1:0] s_ready;
    logic [1:0] s_gid;
    logic [7:0] s_data;
    int         en_cnt, ld_cnt;

    // One clock: drive at negedge, sample 1ns later, advance serializer.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = (src_q[i].size() != 0);
            bus.req_data[i*8 +: 8] = (src_q[i].size() != 0)
                                     ? src_q[i][0] : 8'h00;
        end
        bus.uart_tx_busy = stall || (ser_cnt > 0);
        #1;
        s_en    = bus.uart_tx_en;
        s_ready = bus.req_ready;
        s_ld    = bus.line_done;
        s_ga    = bus.grant_active;
        s_gid   = bus.grant_id;
        s_data  = bus.uart_tx_data;
        if (s_en) begin
            en_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_byte: got %02h, required no byte", s_data);
            end else begin
                e = exp_q.pop_front();
                if (s_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_byte: got %02h, required %02h",
                             s_data, e);
                end
            end
            n_checks++;
            if (prev_en) begin
                n_fail++;
                $display("FAIL en_b2b: got en twice, required gap");
            end
        end
        if (s_ready != '0) begin
            n_checks++;
            if (!$onehot(s_ready) || !s_en) begin
                n_fail++;
                $display("FAIL ready_1hot: got %b en=%0b, required onehot with en",
                         s_ready, s_en);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_ready[i] && src_q[i].size() != 0) begin
                void'(src_q[i].pop_front());
            end
        end
        if (s_ld) ld_cnt++;
        if (s_ga && !prev_ga) grant_log.push_back(int'(s_gid));
        prev_ga = s_ga;
        prev_en = s_en;
        @(posedge clk);
        if (ser_cnt > 0) ser_cnt--;
        if (s_en) ser_cnt = FRAME;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 50 && ser_cnt > 0; k++) tick();
        grant_log.delete();
        en_cnt  = 0;
        ld_cnt  = 0;
        prev_ga = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks += 6;
        if (s_ready !== '0) begin
            n_fail++; $display("FAIL rst_ready: got %b, required 0", s_ready);
        end
        if (s_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_en: got %0b, required 0", s_en);
        end
        if (s_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_data: got %02h, required 00", s_data);
        end
        if (s_gid !== 2'd0) begin
            n_fail++; $display("FAIL rst_gid: got %0d, required 0", s_gid);
        end
        if (s_ga !== 1'b0) begin
            n_fail++; $display("FAIL rst_ga: got %0b, required 0", s_ga);
        end
        if (s_ld !== 1'b0) begin
            n_fail++; $display("FAIL rst_ld: got %0b, required 0", s_ld);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] msg [3] = '{8'h68, 8'h69, 8'h0a};
        int gid_bad = 0;
        do_reset();
        foreach (msg[k]) begin
            src_q[1].push_back(msg[k]);
            exp_q.push_back(msg[k]);
        end
        for (int c = 0; c < 300 && ld_cnt == 0; c++) begin
            tick();
            if (s_ga && s_gid != 2'd1) gid_bad++;
        end
        n_checks += 4;
        if (ld_cnt != 1) begin
            n_fail++; $display("FAIL single_ld: got %0d, required 1", ld_cnt);
        end
        if (en_cnt != 3) begin
            n_fail++; $display("FAIL single_en: got %0d, required 3", en_cnt);
        end
        if (gid_bad != 0) begin
            n_fail++; $display("FAIL single_gid: got %0d bad, required 0", gid_bad);
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL single_sb: got %0d left, required 0",
                               exp_q.size());
        end
        tick();
        n_checks++;
        if (s_ga !== 1'b0) begin
            n_fail++; $display("FAIL single_rel: got %0b, required 0", s_ga);
        end
    endtask

    task automatic test_contention();
        logic [7:0] a [3] = '{8'h41, 8'h42, 8'h0a};
        logic [7:0] b [3] = '{8'h43, 8'h44, 8'h0a};
        int early = 0;
        do_reset();
        foreach (a[k]) begin
            src_q[0].push_back(a[k]);
            src_q[2].push_back(b[k]);
        end
        foreach (a[k]) exp_q.push_back(a[k]);
        foreach (b[k]) exp_q.push_back(b[k]);
        for (int c = 0; c < 500 && ld_cnt < 2; c++) begin
            tick();
            if (s_ready[2] && ld_cnt == 0) early++;
        end
        n_checks += 4;
        if (ld_cnt != 2) begin
            n_fail++; $display("FAIL cont_ld: got %0d, required 2", ld_cnt);
        end
        if (early != 0) begin
            n_fail++; $display("FAIL cont_early: got %0d, required 0", early);
        end
        if (en_cnt != 6) begin
            n_fail++; $display("FAIL cont_en: got %0d, required 6", en_cnt);
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL cont_sb: got %0d left, required 0",
                               exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_q[i].push_back(8'h0a);
            src_q[i].push_back(8'h0a);
        end
        for (int k = 0; k < 2 * N; k++) exp_q.push_back(8'h0a);
        for (int c = 0; c < 600 && ld_cnt < 2 * N; c++) tick();
        n_checks++;
        if (grant_log.size() < 6) begin
            n_fail++; $display("FAIL rr_count: got %0d, required >=6",
                               grant_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (grant_log[k] != k % N) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d, required %0d",
                             k, grant_log[k], k % N);
                end
            end
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        stall = 1'b1;
        src_q[0].push_back(8'h55);
        exp_q.push_back(8'h55);
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (s_en || s_ready != '0) bad++;
        end
        n_checks += 2;
        if (bad != 0) begin
            n_fail++; $display("FAIL stall_quiet: got %0d strobes, required 0", bad);
        end
        if (s_ga !== 1'b1 || s_gid !== 2'd0) begin
            n_fail++; $display("FAIL stall_grant: got ga=%0b id=%0d, required 1/0",
                               s_ga, s_gid);
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (s_en !== 1'b1 || s_ready !== 4'b0001) begin
            n_fail++; $display("FAIL stall_issue: got en=%0b rdy=%b, required 1/0001",
                               s_en, s_ready);
        end
        src_q[0].push_back(8'h0a);
        exp_q.push_back(8'h0a);
        for (int c = 0; c < 200 && ld_cnt == 0; c++) tick();
        n_checks++;
        if (ld_cnt != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stall_line: got ld=%0d left=%0d, required 1/0",
                               ld_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        src_q[3].push_back(8'h58);
        exp_q.push_back(8'h58);
        for (int c = 0; c < 50 && en_cnt == 0; c++) tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_checks += 4;
        if (s_ga !== 1'b0 || s_gid !== 2'd0) begin
            n_fail++; $display("FAIL mid_grant: got ga=%0b id=%0d, required 0/0",
                               s_ga, s_gid);
        end
        if (s_en !== 1'b0 || s_ready !== '0) begin
            n_fail++; $display("FAIL mid_strobe: got en=%0b rdy=%b, required 0/0",
                               s_en, s_ready);
        end
        if (s_data !== 8'h00 || s_ld !== 1'b0) begin
            n_fail++; $display("FAIL mid_data: got %02h ld=%0b, required 00/0",
                               s_data, s_ld);
        end
        if (ser_cnt == 0) begin
            n_fail++; $display("FAIL mid_frame: got idle serializer, required busy");
        end
        grant_log.delete();
        ld_cnt = 0;
        src_q[3].push_back(8'h51);
        src_q[3].push_back(8'h0a);
        src_q[0].push_back(8'h5a);
        src_q[0].push_back(8'h0a);
        exp_q.push_back(8'h5a);
        exp_q.push_back(8'h0a);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h0a);
        for (int c = 0; c < 400 && ld_cnt < 2; c++) tick();
        n_checks += 2;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            n_fail++; $display("FAIL mid_first: got %0d grants, required first 0",
                               grant_log.size());
        end
        if (ld_cnt != 2 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL mid_lines: got ld=%0d left=%0d, required 2/0",
                               ld_cnt, exp_q.size());
        end
    endtask

    task automatic test_owner_hold();
        int r1 = 0;
        do_reset();
        src_q[0].push_back(8'h41);
        src_q[1].push_back(8'h42);
        src_q[1].push_back(8'h0a);
        exp_q.push_back(8'h41);
`ifdef UART_TX_ARB_TIMEOUT_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h0a);
`endif
        for (int c = 0; c < 300; c++) begin
            tick();
            if (s_ready[1]) r1++;
        end
        n_checks += 2;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL hold_sb: got %0d left, required 0",
                               exp_q.size());
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (ld_cnt != 1 || r1 != 2) begin
            n_fail++; $display("FAIL to_release: got ld=%0d r1=%0d, required 1/2",
                               ld_cnt, r1);
        end
`else
        if (ld_cnt != 0 || r1 != 0 || s_gid !== 2'd0 || s_ga !== 1'b1) begin
            n_fail++; $display("FAIL hold_starve: got ld=%0d r1=%0d id=%0d, required 0/0/0",
                               ld_cnt, r1, s_gid);
        end
`endif
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.uart_tx_busy = 1'b0;
        prev_ga          = 1'b0;
        prev_en          = 1'b0;
        en_cnt           = 0;
        ld_cnt           = 0;
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_stall();
        test_reset_mid_line();
        test_owner_hold();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
